// File: rtl/multi_obstacle_collision_scanner.sv
`default_nettype none
// ============================================================================
// Module   : multi_obstacle_collision_scanner
// Purpose  : Walks every edge of up to NUM_OBSTACLES polygons held in an
//            external synchronous vertex RAM and reports the earliest entering
//            intersection with the motion segment P -> P+D as an exact
//            rational time t = t_num/t_den.
// Revision : 1.0  initial multi-obstacle earliest-hit release
// ============================================================================
module multi_obstacle_collision_scanner #(
    parameter int WIDTH         = 16,
    parameter int NUM_OBSTACLES = 4,
    parameter int MAX_VERTICES  = 8,
    localparam int OW = (NUM_OBSTACLES > 1) ? $clog2(NUM_OBSTACLES) : 1,
    localparam int VW = $clog2(MAX_VERTICES + 1),
    localparam int AW = (NUM_OBSTACLES * MAX_VERTICES > 1) ? $clog2(NUM_OBSTACLES * MAX_VERTICES) : 1,
    localparam int PW = 2 * WIDTH + 3
) (
    input  logic                             clk_in,
    input  logic                             rst_in,
    input  logic                             start_in,
    input  logic signed [WIDTH-1:0]          pos_x_in,
    input  logic signed [WIDTH-1:0]          pos_y_in,
    input  logic signed [WIDTH-1:0]          dx_in,
    input  logic signed [WIDTH-1:0]          dy_in,
    input  logic [NUM_OBSTACLES-1:0]         obstacle_en_in,
    input  logic [NUM_OBSTACLES-1:0][VW-1:0] num_vertices_in,
    output logic                             vert_rd_en_out,
    output logic [AW-1:0]                    vert_addr_out,
    input  logic signed [WIDTH-1:0]          vert_x_in,
    input  logic signed [WIDTH-1:0]          vert_y_in,
    output logic                             busy_out,
    output logic                             result_valid_out,
    input  logic                             result_ready_in,
    output logic                             hit_out,
    output logic [OW-1:0]                    hit_obstacle_out,
    output logic [VW-1:0]                    hit_edge_out,
    output logic signed [PW-1:0]             t_num_out,
    output logic signed [PW-1:0]             t_den_out,
    output logic signed [WIDTH:0]            edge_dx_out,
    output logic signed [WIDTH:0]            edge_dy_out
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SEL  = 3'd1,
        ST_RD0  = 3'd2,
        ST_RDK  = 3'd3,
        ST_TEST = 3'd4,
        ST_DONE = 3'd5
    } state_t;

    localparam logic [VW-1:0] c_max_nv  = VW'(MAX_VERTICES);
    localparam logic [OW:0]   c_obj_end = (OW + 1)'(NUM_OBSTACLES);

    state_t                          r_state;
    logic                            r_busy;
    logic                            r_valid;
    logic [OW:0]                     r_obj;
    logic [VW-1:0]                   r_k;
    logic signed [WIDTH-1:0]         r_px, r_py, r_dx, r_dy;
    logic [NUM_OBSTACLES-1:0]        r_en;
    logic [NUM_OBSTACLES-1:0][VW-1:0] r_nv;
    logic signed [WIDTH-1:0]         r_first_x, r_first_y;
    logic signed [WIDTH-1:0]         r_prev_x, r_prev_y;
    logic signed [WIDTH-1:0]         r_cur_x, r_cur_y;
    logic                            r_hit;
    logic [OW-1:0]                   r_hit_obj;
    logic [VW-1:0]                   r_hit_edge;
    logic signed [PW-1:0]            r_best_tn, r_best_den;
    logic signed [WIDTH:0]           r_best_ex, r_best_ey;

    logic [OW-1:0]                   w_slot;
    logic [VW-1:0]                   w_nv;
    logic                            w_obj_done;
    logic                            w_skip;
    logic signed [PW-1:0]            w_ex, w_ey, w_rx, w_ry, w_dx, w_dy;
    logic signed [PW-1:0]            w_den, w_tn, w_un;
    logic signed [2*PW-1:0]          w_lhs, w_rhs;
    logic                            w_hit;
    logic                            w_better;
    logic                            w_rd;
    logic [VW-1:0]                   w_vidx;

    assign w_slot     = r_obj[OW-1:0];
    assign w_nv       = r_nv[w_slot];
    assign w_obj_done = (r_obj == c_obj_end);
    assign w_skip     = !r_en[w_slot] || (w_nv < VW'(3));

    // Edge/segment intersection terms, widened to PW so every product is exact
    assign w_ex  = PW'(r_cur_x) - PW'(r_prev_x);
    assign w_ey  = PW'(r_cur_y) - PW'(r_prev_y);
    assign w_rx  = PW'(r_prev_x) - PW'(r_px);
    assign w_ry  = PW'(r_prev_y) - PW'(r_py);
    assign w_dx  = PW'(r_dx);
    assign w_dy  = PW'(r_dy);
    assign w_den = w_ex * w_dy - w_ey * w_dx;
    assign w_tn  = w_ex * w_ry - w_ey * w_rx;
    assign w_un  = w_dx * w_ry - w_dy * w_rx;

    // Entering only (den > 0), and both parameters inside [0, 1]
    assign w_hit = !w_den[PW-1] && (w_den != '0) &&
                   !w_tn[PW-1] && (w_tn <= w_den) &&
                   !w_un[PW-1] && (w_un <= w_den);

    // Cross-multiplied time compare; strict less-than keeps the earlier edge on ties
    assign w_lhs    = (2 * PW)'(w_tn) * (2 * PW)'(r_best_den);
    assign w_rhs    = (2 * PW)'(r_best_tn) * (2 * PW)'(w_den);
    assign w_better = w_hit && (!r_hit || (w_lhs < w_rhs));

    // RAM read strobe is combinational so data lands in the following state
    always_comb begin
        w_rd   = 1'b0;
        w_vidx = '0;
        case (r_state)
            ST_SEL:  w_rd = !w_obj_done && !w_skip;
            ST_RD0: begin
                w_rd   = 1'b1;
                w_vidx = VW'(1);
            end
            ST_TEST: begin
                w_vidx = r_k + VW'(1);
                w_rd   = (r_k != w_nv) && (w_vidx < w_nv);
            end
            default: w_rd = 1'b0;
        endcase
        if (rst_in) begin
            w_rd = 1'b0;
        end
    end

    assign vert_rd_en_out = w_rd;
    assign vert_addr_out  = w_rd ? AW'(int'(w_slot) * MAX_VERTICES + int'(w_vidx)) : '0;

    assign busy_out         = r_busy;
    assign result_valid_out = r_valid;
    assign hit_out          = r_hit;
    assign hit_obstacle_out = r_hit_obj;
    assign hit_edge_out     = r_hit_edge;
    assign t_num_out        = r_best_tn;
    assign t_den_out        = r_best_den;
    assign edge_dx_out      = r_best_ex;
    assign edge_dy_out      = r_best_ey;

    // Scan sequencer: slot selection, vertex fetch, edge test and best-hit tracking
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state    <= ST_IDLE;
            r_busy     <= 1'b0;
            r_valid    <= 1'b0;
            r_obj      <= '0;
            r_k        <= '0;
            r_px       <= '0;
            r_py       <= '0;
            r_dx       <= '0;
            r_dy       <= '0;
            r_en       <= '0;
            r_nv       <= '0;
            r_first_x  <= '0;
            r_first_y  <= '0;
            r_prev_x   <= '0;
            r_prev_y   <= '0;
            r_cur_x    <= '0;
            r_cur_y    <= '0;
            r_hit      <= 1'b0;
            r_hit_obj  <= '0;
            r_hit_edge <= '0;
            r_best_tn  <= '0;
            r_best_den <= '0;
            r_best_ex  <= '0;
            r_best_ey  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start_in) begin
                        r_px <= pos_x_in;
                        r_py <= pos_y_in;
                        r_dx <= dx_in;
                        r_dy <= dy_in;
                        r_en <= obstacle_en_in;
                        for (int i = 0; i < NUM_OBSTACLES; i++) begin
                            r_nv[i] <= (num_vertices_in[i] > c_max_nv) ? c_max_nv : num_vertices_in[i];
                        end
                        r_obj      <= '0;
                        r_hit      <= 1'b0;
                        r_hit_obj  <= '0;
                        r_hit_edge <= '0;
                        r_best_tn  <= '0;
                        r_best_den <= '0;
                        r_best_ex  <= '0;
                        r_best_ey  <= '0;
                        r_busy     <= 1'b1;
                        r_state    <= ST_SEL;
                    end
                end
                ST_SEL: begin
                    if (w_obj_done) begin
                        r_valid <= 1'b1;
                        r_state <= ST_DONE;
                    end else if (w_skip) begin
                        r_obj <= r_obj + (OW + 1)'(1);
                    end else begin
                        r_k     <= VW'(1);
                        r_state <= ST_RD0;
                    end
                end
                ST_RD0: begin
                    r_first_x <= vert_x_in;
                    r_first_y <= vert_y_in;
                    r_prev_x  <= vert_x_in;
                    r_prev_y  <= vert_y_in;
                    r_state   <= ST_RDK;
                end
                ST_RDK: begin
                    // Past the last vertex the polygon closes back onto vertex 0
                    if (r_k < w_nv) begin
                        r_cur_x <= vert_x_in;
                        r_cur_y <= vert_y_in;
                    end else begin
                        r_cur_x <= r_first_x;
                        r_cur_y <= r_first_y;
                    end
                    r_state <= ST_TEST;
                end
                ST_TEST: begin
                    if (w_better) begin
                        r_hit      <= 1'b1;
                        r_hit_obj  <= w_slot;
                        r_hit_edge <= r_k - VW'(1);
                        r_best_tn  <= w_tn;
                        r_best_den <= w_den;
                        r_best_ex  <= w_ex[WIDTH:0];
                        r_best_ey  <= w_ey[WIDTH:0];
                    end
                    r_prev_x <= r_cur_x;
                    r_prev_y <= r_cur_y;
                    if (r_k == w_nv) begin
                        r_obj   <= r_obj + (OW + 1)'(1);
                        r_state <= ST_SEL;
                    end else begin
                        r_k     <= r_k + VW'(1);
                        r_state <= ST_RDK;
                    end
                end
                ST_DONE: begin
                    if (result_ready_in) begin
                        r_valid <= 1'b0;
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_multi_obstacle_collision_scanner.sv
`default_nettype none
// ============================================================================
// Module   : tb_multi_obstacle_collision_scanner
// Purpose  : Directed and randomized scans of multi_obstacle_collision_scanner
//            against an arithmetic reference model of the hit rules.
// Revision : 1.0  initial bench
// ============================================================================
module tb_multi_obstacle_collision_scanner;

    localparam int WIDTH = 16;
    localparam int NOB   = 4;
    localparam int MV    = 8;
    localparam int VW    = 4;
    localparam int AW    = 5;
    localparam int OW    = 2;
    localparam int PW    = 35;

    logic                          clk_in = 1'b0;
    logic                          rst_in;
    logic                          start_in;
    logic signed [WIDTH-1:0]       pos_x_in, pos_y_in, dx_in, dy_in;
    logic [NOB-1:0]                obstacle_en_in;
    logic [NOB-1:0][VW-1:0]        num_vertices_in;
    logic                          vert_rd_en_out;
    logic [AW-1:0]                 vert_addr_out;
    logic signed [WIDTH-1:0]       vert_x_in, vert_y_in;
    logic                          busy_out, result_valid_out, result_ready_in;
    logic                          hit_out;
    logic [OW-1:0]                 hit_obstacle_out;
    logic [VW-1:0]                 hit_edge_out;
    logic signed [PW-1:0]          t_num_out, t_den_out;
    logic signed [WIDTH:0]         edge_dx_out, edge_dy_out;

    int tests = 0;
    int fails = 0;

    // Vertex RAM contents and the configuration of the next scan
    logic signed [WIDTH-1:0] mem_x [NOB*MV];
    logic signed [WIDTH-1:0] mem_y [NOB*MV];
    longint cfg_px, cfg_py, cfg_dx, cfg_dy;
    logic [NOB-1:0] cfg_en;
    int cfg_nv [NOB];

    // Reference results
    longint exp_hit, exp_obj, exp_edge, exp_tn, exp_td, exp_ex, exp_ey;
    int     exp_lat;
    int     exp_addr[$];
    int     rd_q[$];

    // Observed values kept for directed spot checks
    longint obs_lat, obs_obj, obs_tn, obs_td, obs_nrd;

    multi_obstacle_collision_scanner #(
        .WIDTH(WIDTH), .NUM_OBSTACLES(NOB), .MAX_VERTICES(MV)
    ) dut (
        .clk_in(clk_in), .rst_in(rst_in), .start_in(start_in),
        .pos_x_in(pos_x_in), .pos_y_in(pos_y_in), .dx_in(dx_in), .dy_in(dy_in),
        .obstacle_en_in(obstacle_en_in), .num_vertices_in(num_vertices_in),
        .vert_rd_en_out(vert_rd_en_out), .vert_addr_out(vert_addr_out),
        .vert_x_in(vert_x_in), .vert_y_in(vert_y_in),
        .busy_out(busy_out), .result_valid_out(result_valid_out),
        .result_ready_in(result_ready_in), .hit_out(hit_out),
        .hit_obstacle_out(hit_obstacle_out), .hit_edge_out(hit_edge_out),
        .t_num_out(t_num_out), .t_den_out(t_den_out),
        .edge_dx_out(edge_dx_out), .edge_dy_out(edge_dy_out)
    );

    always #5 clk_in = ~clk_in;

    // Synchronous RAM with one cycle read latency; also logs every read address
    always @(posedge clk_in) begin
        if (vert_rd_en_out) begin
            vert_x_in <= mem_x[vert_addr_out];
            vert_y_in <= mem_y[vert_addr_out];
            rd_q.push_back(int'(vert_addr_out));
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int rnd(input int lo, input int hi);
        return lo + int'($urandom_range(hi - lo));
    endfunction

    task automatic load_rect(input int s, input int x0, input int y0, input int w, input int h);
        mem_x[s*MV+0] = 16'(x0);     mem_y[s*MV+0] = 16'(y0);
        mem_x[s*MV+1] = 16'(x0 + w); mem_y[s*MV+1] = 16'(y0);
        mem_x[s*MV+2] = 16'(x0 + w); mem_y[s*MV+2] = 16'(y0 + h);
        mem_x[s*MV+3] = 16'(x0);     mem_y[s*MV+3] = 16'(y0 + h);
    endtask

    // Earliest entering hit over all qualifying polygons, from the segment/edge equations
    task automatic model();
        longint ax, ay, bx, by, ex, ey, rx, ry, den, tn, un;
        int nv;
        exp_hit = 0; exp_obj = 0; exp_edge = 0; exp_tn = 0; exp_td = 0; exp_ex = 0; exp_ey = 0;
        exp_lat = 2;
        exp_addr.delete();
        for (int s = 0; s < NOB; s++) begin
            nv = (cfg_nv[s] > MV) ? MV : cfg_nv[s];
            if (!cfg_en[s] || nv < 3) begin
                exp_lat += 1;
            end else begin
                exp_lat += 2 + 2 * nv;
                for (int v = 0; v < nv; v++) exp_addr.push_back(s * MV + v);
                for (int i = 0; i < nv; i++) begin
                    ax = mem_x[s*MV+i];            ay = mem_y[s*MV+i];
                    bx = mem_x[s*MV+(i+1)%nv];     by = mem_y[s*MV+(i+1)%nv];
                    ex = bx - ax; ey = by - ay;
                    rx = ax - cfg_px; ry = ay - cfg_py;
                    den = ex * cfg_dy - ey * cfg_dx;
                    tn  = ex * ry - ey * rx;
                    un  = cfg_dx * ry - cfg_dy * rx;
                    if (den > 0 && tn >= 0 && tn <= den && un >= 0 && un <= den) begin
                        if (exp_hit == 0 || tn * exp_td < exp_tn * den) begin
                            exp_hit = 1; exp_obj = s; exp_edge = i;
                            exp_tn = tn; exp_td = den; exp_ex = ex; exp_ey = ey;
                        end
                    end
                end
            end
        end
    endtask

    task automatic scramble();
        pos_x_in = 16'($urandom); pos_y_in = 16'($urandom);
        dx_in = 16'($urandom);    dy_in = 16'($urandom);
        obstacle_en_in = 4'($urandom);
        num_vertices_in = 16'($urandom);
    endtask

    task automatic drive_cfg();
        pos_x_in = 16'(cfg_px); pos_y_in = 16'(cfg_py);
        dx_in = 16'(cfg_dx);    dy_in = 16'(cfg_dy);
        obstacle_en_in = cfg_en;
        for (int s = 0; s < NOB; s++) num_vertices_in[s] = 4'(cfg_nv[s]);
    endtask

    task automatic run_scan(input string name, input int hold);
        int lat;
        bit got;
        model();
        rd_q.delete();
        @(negedge clk_in);
        drive_cfg();
        start_in = 1'b1;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 400) begin
            @(posedge clk_in);
            lat++;
            #1;
            if (lat == 1) begin
                start_in = 1'b0;
                scramble();
            end
            got = result_valid_out;
        end
        obs_lat = lat; obs_obj = hit_obstacle_out; obs_tn = t_num_out; obs_td = t_den_out;
        obs_nrd = rd_q.size();
        chk({name, "_latency"}, lat, exp_lat);
        chk({name, "_hit"}, hit_out, exp_hit);
        chk({name, "_obstacle"}, hit_obstacle_out, exp_obj);
        chk({name, "_edge"}, hit_edge_out, exp_edge);
        chk({name, "_t_num"}, t_num_out, exp_tn);
        chk({name, "_t_den"}, t_den_out, exp_td);
        chk({name, "_edge_dx"}, edge_dx_out, exp_ex);
        chk({name, "_edge_dy"}, edge_dy_out, exp_ey);
        chk({name, "_busy"}, busy_out, 1);
        chk({name, "_nreads"}, rd_q.size(), exp_addr.size());
        for (int i = 0; i < rd_q.size() && i < exp_addr.size(); i++)
            chk({name, "_rd_addr"}, rd_q[i], exp_addr[i]);
        for (int c = 0; c < hold; c++) begin
            @(negedge clk_in);
            start_in = 1'b1;
            scramble();
            @(posedge clk_in);
            #1;
            chk({name, "_hold_valid"}, result_valid_out, 1);
            chk({name, "_hold_t_num"}, t_num_out, exp_tn);
            chk({name, "_hold_obstacle"}, hit_obstacle_out, exp_obj);
        end
        if (hold > 0) chk({name, "_hold_nreads"}, rd_q.size(), exp_addr.size());
        @(negedge clk_in);
        start_in = 1'b0;
        result_ready_in = 1'b1;
        @(posedge clk_in);
        #1;
        chk({name, "_valid_drop"}, result_valid_out, 0);
        chk({name, "_idle"}, busy_out, 0);
        @(negedge clk_in);
        result_ready_in = 1'b0;
    endtask

    initial begin
        int n_before;
        rst_in = 1'b1;
        start_in = 1'b0;
        result_ready_in = 1'b0;
        vert_x_in = '0;
        vert_y_in = '0;
        for (int a = 0; a < NOB * MV; a++) begin
            mem_x[a] = '0;
            mem_y[a] = '0;
        end
        cfg_px = 0; cfg_py = 0; cfg_dx = 0; cfg_dy = 0; cfg_en = '0;
        for (int s = 0; s < NOB; s++) cfg_nv[s] = 0;
        drive_cfg();
        repeat (3) @(posedge clk_in);
        #1;
        chk("rst_busy", busy_out, 0);
        chk("rst_valid", result_valid_out, 0);
        chk("rst_hit", hit_out, 0);
        chk("rst_obstacle", hit_obstacle_out, 0);
        chk("rst_edge", hit_edge_out, 0);
        chk("rst_t_num", t_num_out, 0);
        chk("rst_t_den", t_den_out, 0);
        chk("rst_edge_dx", edge_dx_out, 0);
        chk("rst_edge_dy", edge_dy_out, 0);
        chk("rst_rd_en", vert_rd_en_out, 0);
        chk("rst_addr", vert_addr_out, 0);
        @(negedge clk_in);
        rst_in = 1'b0;

        // Single square, hit on its left edge
        load_rect(0, 10, 10, 10, 10);
        cfg_en = 4'b0001;
        cfg_nv = '{4, 0, 0, 0};
        cfg_px = 0; cfg_py = 15; cfg_dx = 20; cfg_dy = 0;
        run_scan("square", 0);
        chk("square_lat_is_15", obs_lat, 15);
        chk("square_tnum_is_100", obs_tn, 100);
        chk("square_tden_is_200", obs_td, 200);

        // Too short, parallel, and exit-only cases
        cfg_dx = 5; cfg_dy = 0;
        run_scan("short", 0);
        cfg_dx = 0; cfg_dy = 20;
        run_scan("parallel", 0);
        cfg_px = 15; cfg_py = 15; cfg_dx = 20; cfg_dy = 0;
        run_scan("exit_only", 0);

        // Earliest of two squares on the same ray
        load_rect(0, 40, 10, 10, 10);
        load_rect(1, 10, 10, 10, 10);
        cfg_en = 4'b0011;
        cfg_nv = '{4, 4, 0, 0};
        cfg_px = 0; cfg_py = 15; cfg_dx = 60; cfg_dy = 0;
        run_scan("earliest", 0);
        chk("earliest_obstacle_is_1", obs_obj, 1);
        chk("earliest_tnum_is_100", obs_tn, 100);

        // Identical squares tie: lower slot wins
        load_rect(2, 10, 10, 10, 10);
        load_rect(3, 10, 10, 10, 10);
        cfg_en = 4'b1100;
        cfg_nv = '{0, 0, 4, 4};
        cfg_dx = 20;
        run_scan("tie", 0);
        chk("tie_obstacle_is_2", obs_obj, 2);

        // Skips, clipped vertex count, and a stalled consumer
        mem_x[16] = 10; mem_y[16] = 0;  mem_x[17] = 20; mem_y[17] = 0;
        mem_x[18] = 30; mem_y[18] = 10; mem_x[19] = 30; mem_y[19] = 20;
        mem_x[20] = 20; mem_y[20] = 30; mem_x[21] = 10; mem_y[21] = 30;
        mem_x[22] = 0;  mem_y[22] = 20; mem_x[23] = 0;  mem_y[23] = 10;
        cfg_en = 4'b0101;
        cfg_nv = '{2, 4, 12, 4};
        cfg_px = -10; cfg_py = 15; cfg_dx = 50; cfg_dy = 0;
        run_scan("skips", 5);
        chk("skips_lat_is_23", obs_lat, 23);
        chk("skips_eight_reads", obs_nrd, 8);

        // Reset while an edge is under test
        load_rect(0, 10, 10, 10, 10);
        cfg_en = 4'b0001;
        cfg_nv = '{4, 0, 0, 0};
        cfg_px = 0; cfg_py = 15; cfg_dx = 20; cfg_dy = 0;
        @(negedge clk_in);
        drive_cfg();
        start_in = 1'b1;
        @(posedge clk_in);
        #1;
        start_in = 1'b0;
        repeat (5) @(posedge clk_in);
        @(negedge clk_in);
        rst_in = 1'b1;
        #1;
        chk("midrst_no_strobe", vert_rd_en_out, 0);
        n_before = rd_q.size();
        @(posedge clk_in);
        #1;
        chk("midrst_busy", busy_out, 0);
        chk("midrst_valid", result_valid_out, 0);
        @(negedge clk_in);
        rst_in = 1'b0;
        repeat (5) @(posedge clk_in);
        #1;
        chk("midrst_no_reads", rd_q.size(), n_before);
        chk("midrst_stay_idle", busy_out, 0);
        chk("midrst_no_result", result_valid_out, 0);

        // Randomized polygons, enables and vertex counts
        for (int it = 0; it < 30; it++) begin
            for (int a = 0; a < NOB * MV; a++) begin
                mem_x[a] = 16'(rnd(-100, 100));
                mem_y[a] = 16'(rnd(-100, 100));
            end
            for (int s = 0; s < NOB; s++) begin
                if ($urandom_range(1) == 0) begin
                    load_rect(s, rnd(-60, 60), rnd(-60, 60), rnd(1, 40), rnd(1, 40));
                    cfg_nv[s] = 4;
                end else begin
                    cfg_nv[s] = rnd(0, 15);
                end
            end
            cfg_en = 4'($urandom);
            cfg_px = rnd(-150, 150); cfg_py = rnd(-150, 150);
            cfg_dx = rnd(-300, 300); cfg_dy = rnd(-300, 300);
            run_scan("random", rnd(0, 2));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
